// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: turns a single-cycle load/store request into a req/done
// handshake with a variable-latency data memory, stalling upstream until it retires.
module mem_access_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Halt,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              Err,
    output logic              createdump,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        DONE,
        HALTED,
        ERROR
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             start;
    logic             dump;
    logic             any_access;

    assign any_access = MemRead | MemWrite;

    // Next-state, stall and launch decisions
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        Stall   = 1'b0;
        start   = 1'b0;
        dump    = 1'b0;
        case (state)
            IDLE: begin
                if (Halt) begin
                    state_n = HALTED;
                    Stall   = 1'b1;
                    dump    = 1'b1;
                end else if (MemRead && MemWrite) begin
                    state_n = ERROR;
                    Stall   = 1'b1;
                end else if (any_access && Address[0]) begin
                    state_n = ERROR;
                    Stall   = 1'b1;
                end else if (any_access) begin
                    state_n = ACCESS;
                    Stall   = 1'b1;
                    start   = 1'b1;
                    cnt_n   = '0;
                end
            end
            ACCESS: begin
                Stall = 1'b1;
                cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                // A completion on the timeout cycle still retires the access
                if (mem_done) begin
                    state_n = DONE;
                end else if (cnt_n == CNT_LIMIT) begin
                    state_n = ERROR;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            HALTED: begin
                Stall = 1'b1;
            end
            ERROR: begin
                Stall = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ReadData   <= '0;
            Err        <= 1'b0;
            createdump <= 1'b0;
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            mem_req    <= start;
            createdump <= dump;
            if (start) begin
                mem_addr  <= Address;
                mem_wdata <= WriteData;
                mem_wr    <= MemWrite;
            end
            if (state == ACCESS && mem_done && !mem_wr) begin
                ReadData <= mem_rdata;
            end
            if (state_n == ERROR) begin
                Err <= 1'b1;
            end
        end
    end

endmodule
